// File: rtl/usb_frame_pkg.sv
// Shared types and constants for the USB frame packer.
// Contents: FSM state enum, default SOF/EOF words, CRC-16/CCITT constants and
// a one-word CRC step function (MSB first).
// Configuration macro: USB_FRAME_CRC_EN adds the CRC state to the enum.
package usb_frame_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StHead,
        StSeq,
        StBody,
        StCnt,
`ifdef USB_FRAME_CRC_EN
        StCrc,
`endif
        StTail,
        StPend
    } state_e;

    localparam logic [15:0] SOF_WORD_DEFAULT = 16'hA5A5;
    localparam logic [15:0] EOF_WORD_DEFAULT = 16'h5A5A;
    localparam logic [15:0] CRC_POLY         = 16'h1021;
    localparam logic [15:0] CRC_INIT         = 16'hFFFF;

    // Folds one 16-bit word into the running CRC, most significant bit first.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic [15:0] data);
        logic [15:0] c;
        logic        fb;
        c = crc;
        for (int i = 15; i >= 0; i--) begin
            fb = c[15] ^ data[i];
            c  = {c[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
        end
        return c;
    endfunction

endpackage

// File: rtl/usb_frame_fifo.sv
// Synchronous first-word-fall-through FIFO for buffering payload words.
// Ports: clk, reset (sync, active-high), wr_en/wr_data push, rd_en pop,
// rd_data shows the head word whenever empty is low, full/empty status.
// Writes while full and reads while empty are ignored.
module usb_frame_fifo #(
    parameter int unsigned DEPTH_LOG2 = 5,
    parameter int unsigned WIDTH      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0]    mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2:0] wptr_q;
    logic [DEPTH_LOG2:0] rptr_q;
    logic                do_wr;
    logic                do_rd;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[DEPTH_LOG2] != rptr_q[DEPTH_LOG2]) &&
                     (wptr_q[DEPTH_LOG2-1:0] == rptr_q[DEPTH_LOG2-1:0]);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rptr_q[DEPTH_LOG2-1:0]];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wptr_q[DEPTH_LOG2-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_wr) wptr_q <= wptr_q + 1'b1;
            if (do_rd) rptr_q <= rptr_q + 1'b1;
        end
    end

endmodule

// File: rtl/usb_frame_packer.sv
// Frames a 16-bit payload stream into packets for a USB external FIFO.
// Frame: SOF_WORD, sequence number, payload, word count, [CRC], EOF_WORD, then
// a one-cycle active-low PktEnd_n. An idle timeout in BODY also pulses PktEnd_n.
// Ports: Clk, reset (sync, active-high), FrameStart/FrameEnd pulses,
// InData/InData_en payload, UsbFifoFull back-pressure, UsbFifoData/_en write
// port, PktEnd_n, sticky Overflow, FrameSeq (last completed frame), Busy.
// Configuration macro: USB_FRAME_CRC_EN appends a CRC-16/CCITT word.
module usb_frame_packer
    import usb_frame_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2   = 5,
    parameter logic [15:0] SOF_WORD     = SOF_WORD_DEFAULT,
    parameter logic [15:0] EOF_WORD     = EOF_WORD_DEFAULT,
    parameter int unsigned IDLE_TIMEOUT = 1024
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic        FrameStart,
    input  logic        FrameEnd,
    input  logic [15:0] InData,
    input  logic        InData_en,
    input  logic        UsbFifoFull,
    output logic [15:0] UsbFifoData,
    output logic        UsbFifoData_en,
    output logic        PktEnd_n,
    output logic        Overflow,
    output logic [15:0] FrameSeq,
    output logic        Busy
);

    localparam int unsigned IdleW = $clog2(IDLE_TIMEOUT + 1);

    state_e             state_q, state_d;
    logic               out_valid_q, out_valid_d;
    logic [15:0]        out_data_q, out_data_d;
    logic               frame_end_q;
    logic [15:0]        word_cnt_q;
    logic [IdleW-1:0]   idle_cnt_q;
    logic               flush_q;
    logic [15:0]        seq_q;
    logic               overflow_q;
`ifdef USB_FRAME_CRC_EN
    logic [15:0]        crc_q;
`endif

    logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [15:0]        fifo_rdata;
    logic               accept_win, drop, out_accept, out_free, idle_run;

    usb_frame_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (16)
    ) u_fifo (
        .clk     (Clk),
        .reset   (reset),
        .wr_en   (fifo_push),
        .wr_data (InData),
        .rd_en   (fifo_pop),
        .rd_data (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Payload is taken only while the frame body is open; frame_end_q is registered so a
    // word arriving together with FrameEnd still belongs to the frame.
    assign accept_win = ((state_q == StSeq) || (state_q == StBody)) && !frame_end_q;
    assign fifo_push  = InData_en && accept_win && !fifo_full;
    assign drop       = InData_en && ((state_q == StIdle) || (accept_win && fifo_full));
    // The output register holds one pending word; it is written on any cycle with room.
    assign out_accept = out_valid_q && !UsbFifoFull;
    assign out_free   = !out_valid_q || !UsbFifoFull;
    assign idle_run   = (state_q == StBody) && fifo_empty && !frame_end_q;

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q && !out_accept;
        out_data_d  = out_data_q;
        fifo_pop    = 1'b0;
        unique case (state_q)
            StIdle: if (FrameStart) begin
                out_valid_d = 1'b1;
                out_data_d  = SOF_WORD;
                state_d     = StHead;
            end
            StHead: if (out_accept) begin
                out_valid_d = 1'b1;
                out_data_d  = seq_q + 16'd1;
                state_d     = StSeq;
            end
            StSeq: if (out_accept) state_d = StBody;
            StBody: if (out_free) begin
                if (!fifo_empty) begin
                    fifo_pop    = 1'b1;
                    out_valid_d = 1'b1;
                    out_data_d  = fifo_rdata;
                end else if (frame_end_q) begin
                    out_valid_d = 1'b1;
                    out_data_d  = word_cnt_q;
                    state_d     = StCnt;
                end
            end
            StCnt: if (out_accept) begin
                out_valid_d = 1'b1;
`ifdef USB_FRAME_CRC_EN
                out_data_d  = crc_q;
                state_d     = StCrc;
`else
                out_data_d  = EOF_WORD;
                state_d     = StTail;
`endif
            end
`ifdef USB_FRAME_CRC_EN
            StCrc: if (out_accept) begin
                out_valid_d = 1'b1;
                out_data_d  = EOF_WORD;
                state_d     = StTail;
            end
`endif
            StTail: if (out_accept) state_d = StPend;
            StPend: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            frame_end_q <= 1'b0;
            word_cnt_q  <= '0;
            idle_cnt_q  <= '0;
            flush_q     <= 1'b0;
            seq_q       <= '0;
            overflow_q  <= 1'b0;
`ifdef USB_FRAME_CRC_EN
            crc_q       <= CRC_INIT;
`endif
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            if (drop) overflow_q <= 1'b1;
            if (state_q == StIdle) begin
                frame_end_q <= 1'b0;
                word_cnt_q  <= '0;
`ifdef USB_FRAME_CRC_EN
                crc_q       <= CRC_INIT;
`endif
            end else begin
                if (fifo_push) begin
                    word_cnt_q <= word_cnt_q + 16'd1;
`ifdef USB_FRAME_CRC_EN
                    crc_q      <= crc16_step(crc_q, InData);
`endif
                end
                if (FrameEnd && (state_q inside {StHead, StSeq, StBody})) frame_end_q <= 1'b1;
            end
            flush_q <= 1'b0;
            if (fifo_push || !idle_run) begin
                idle_cnt_q <= '0;
            end else if (idle_cnt_q == IdleW'(IDLE_TIMEOUT - 1)) begin
                idle_cnt_q <= '0;
                flush_q    <= 1'b1;
            end else begin
                idle_cnt_q <= idle_cnt_q + 1'b1;
            end
            if (state_q == StPend) seq_q <= seq_q + 16'd1;
        end
    end

    assign UsbFifoData    = out_data_q;
    assign UsbFifoData_en = out_accept;
    assign PktEnd_n       = !((state_q == StPend) || flush_q);
    assign Overflow       = overflow_q;
    assign FrameSeq       = seq_q;
    assign Busy           = (state_q != StIdle);

endmodule

// File: tb/tb_usb_frame_packer.sv
// Directed self-checking bench for usb_frame_packer.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_usb_frame_packer;

    localparam int unsigned IdleTo = 1024;

    logic        Clk = 1'b0;
    logic        reset = 1'b1;
    logic        FrameStart = 1'b0;
    logic        FrameEnd = 1'b0;
    logic [15:0] InData = '0;
    logic        InData_en = 1'b0;
    logic        UsbFifoFull = 1'b0;
    logic [15:0] UsbFifoData;
    logic        UsbFifoData_en;
    logic        PktEnd_n;
    logic        Overflow;
    logic [15:0] FrameSeq;
    logic        Busy;

    int checks = 0;
    int errors = 0;
    int pend_cnt = 0;
    logic [15:0] words [$];
    logic [15:0] exp [$];

    always #5 Clk = ~Clk;

    usb_frame_packer #(
        .DEPTH_LOG2   (5),
        .SOF_WORD     (16'hA5A5),
        .EOF_WORD     (16'h5A5A),
        .IDLE_TIMEOUT (IdleTo)
    ) dut (
        .Clk            (Clk),
        .reset          (reset),
        .FrameStart     (FrameStart),
        .FrameEnd       (FrameEnd),
        .InData         (InData),
        .InData_en      (InData_en),
        .UsbFifoFull    (UsbFifoFull),
        .UsbFifoData    (UsbFifoData),
        .UsbFifoData_en (UsbFifoData_en),
        .PktEnd_n       (PktEnd_n),
        .Overflow       (Overflow),
        .FrameSeq       (FrameSeq),
        .Busy           (Busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Write/strobe monitor; also checks that no write is issued while the FIFO is full.
    always @(negedge Clk) begin
        if (!reset) begin
            if (UsbFifoData_en) words.push_back(UsbFifoData);
            if (!PktEnd_n) pend_cnt++;
            if (UsbFifoFull) chk("write_while_full", {31'b0, UsbFifoData_en}, 32'd0);
        end
    end

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        FrameStart = 1'b1;
        step();
        FrameStart = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max);
        int n;
        n = 0;
        while (Busy && n < max) begin
            step();
            n++;
        end
        chk({tag, "_done"}, {31'b0, Busy}, 32'd0);
    endtask

    task automatic chk_frame(input string tag);
        chk({tag, "_len"}, words.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            if (i < words.size()) chk($sformatf("%s_w%0d", tag, i), {16'b0, words[i]}, {16'b0, exp[i]});
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_data"}, {16'b0, UsbFifoData}, 32'd0);
        chk({tag, "_en"}, {31'b0, UsbFifoData_en}, 32'd0);
        chk({tag, "_pktend"}, {31'b0, PktEnd_n}, 32'd1);
        chk({tag, "_ovf"}, {31'b0, Overflow}, 32'd0);
        chk({tag, "_seq"}, {16'b0, FrameSeq}, 32'd0);
        chk({tag, "_busy"}, {31'b0, Busy}, 32'd0);
    endtask

`ifdef USB_FRAME_CRC_EN
    function automatic logic [15:0] crc_ref(input logic [15:0] w);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 15; i >= 0; i--) begin
            if (c[15] ^ w[i]) c = (c << 1) ^ 16'h1021;
            else c = c << 1;
        end
        return c;
    endfunction
`endif

    initial begin
        logic [15:0] held;
        int n_before;
        int sof_seen;
        int eof_seen;

        // Reset
        step(3);
        reset = 1'b0;
        chk_reset_state("reset");

        // Frame 1: three words, FrameEnd together with the last word
        words.delete();
        pend_cnt = 0;
        pulse_start();
        step();
        InData_en = 1'b1;
        InData = 16'h0001; step();
        InData = 16'h0002; step();
        InData = 16'h0003; FrameEnd = 1'b1; step();
        InData_en = 1'b0; FrameEnd = 1'b0;
        wait_idle("f1", 200);
        step();
        exp = '{16'hA5A5, 16'h0001, 16'h0001, 16'h0002, 16'h0003, 16'h0003, 16'h5A5A};
        chk_frame("f1");
        chk("f1_pktend_cycles", pend_cnt, 1);
        chk("f1_seq", {16'b0, FrameSeq}, 32'd1);

        // Frame 2: USB FIFO full for 10 cycles during the payload
        words.delete();
        pend_cnt = 0;
        pulse_start();
        step();
        InData_en = 1'b1;
        InData = 16'h0001; step();
        InData = 16'h0002; step();
        InData = 16'h0003; step();
        InData_en = 1'b0;
        UsbFifoFull = 1'b1;
        step(2);
        held = UsbFifoData;
        n_before = words.size();
        chk("f2_stall_data", {16'b0, held}, 32'h0002);
        step(8);
        chk("f2_stall_hold", {16'b0, UsbFifoData}, {16'b0, held});
        chk("f2_stall_nowrite", words.size(), n_before);
        UsbFifoFull = 1'b0;
        FrameEnd = 1'b1; step(); FrameEnd = 1'b0;
        wait_idle("f2", 200);
        step();
        exp = '{16'hA5A5, 16'h0002, 16'h0001, 16'h0002, 16'h0003, 16'h0003, 16'h5A5A};
        chk_frame("f2");
        chk("f2_pktend_cycles", pend_cnt, 1);
        chk("f2_seq", {16'b0, FrameSeq}, 32'd2);
        chk("f2_ovf", {31'b0, Overflow}, 32'd0);

        // Frame 3: 40 words while the USB FIFO is full -> 32 kept
        words.delete();
        pulse_start();
        step();
        UsbFifoFull = 1'b1;
        InData_en = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            InData = 16'(i);
            step();
        end
        InData_en = 1'b0;
        chk("f3_ovf", {31'b0, Overflow}, 32'd1);
        UsbFifoFull = 1'b0;
        FrameEnd = 1'b1; step(); FrameEnd = 1'b0;
        wait_idle("f3", 300);
        step();
        exp.delete();
        exp.push_back(16'hA5A5);
        exp.push_back(16'h0003);
        for (int i = 1; i <= 32; i++) exp.push_back(16'(i));
        exp.push_back(16'h0020);
        exp.push_back(16'h5A5A);
        chk_frame("f3");

        // Frame 4: idle flush, frame stays open, then an empty frame closes it
        words.delete();
        pend_cnt = 0;
        pulse_start();
        step(IdleTo + 20);
        chk("f4_flush_pulses", pend_cnt, 1);
        chk("f4_busy", {31'b0, Busy}, 32'd1);
        FrameEnd = 1'b1; step(); FrameEnd = 1'b0;
        wait_idle("f4", 200);
        step();
        exp = '{16'hA5A5, 16'h0004, 16'h0000, 16'h5A5A};
        chk_frame("f4");
        chk("f4_pulses_total", pend_cnt, 2);
        chk("f4_seq", {16'b0, FrameSeq}, 32'd4);

        // Frame 5: FrameStart mid-frame ignored, reset mid-payload drops the frame
        words.delete();
        pulse_start();
        step();
        InData_en = 1'b1;
        InData = 16'h0011; step();
        InData = 16'h0012; FrameStart = 1'b1; step();
        FrameStart = 1'b0;
        InData = 16'h0013; step();
        InData_en = 1'b0;
        step(3);
        reset = 1'b1;
        step(2);
        sof_seen = 0;
        eof_seen = 0;
        foreach (words[i]) begin
            if (words[i] == 16'hA5A5) sof_seen++;
            if (words[i] == 16'h5A5A) eof_seen++;
        end
        chk("f5_single_sof", sof_seen, 1);
        chk("f5_no_eof", eof_seen, 0);
        reset = 1'b0;
        chk_reset_state("f5_reset");
        words.delete();
        pulse_start();
        step();
        InData_en = 1'b1; InData = 16'h00AB; FrameEnd = 1'b1; step();
        InData_en = 1'b0; FrameEnd = 1'b0;
        wait_idle("f6", 200);
        step();
        exp = '{16'hA5A5, 16'h0001, 16'h00AB, 16'h0001, 16'h5A5A};
        chk_frame("f6");
        chk("f6_seq", {16'b0, FrameSeq}, 32'd1);

`ifdef USB_FRAME_CRC_EN
        // CRC frame: single payload word 0x1234
        words.delete();
        pulse_start();
        step();
        InData_en = 1'b1; InData = 16'h1234; FrameEnd = 1'b1; step();
        InData_en = 1'b0; FrameEnd = 1'b0;
        wait_idle("crc", 200);
        step();
        exp = '{16'hA5A5, 16'h0002, 16'h1234, 16'h0001, crc_ref(16'h1234), 16'h5A5A};
        chk_frame("crc");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
